// File: rtl/puf_pkg.sv
// Shared types and constants for the arbiter-PUF challenge/response sequencer.
package puf_pkg;

    localparam int CHAL_W = 8;
    localparam logic [CHAL_W-1:0] LFSR_POLY = 8'hB8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LAUNCH,
        S_HOLD,
        S_SAMPLE,
        S_NEXT,
        S_DONE
    } state_t;

    // Galois right-shift step: shift, then fold the polynomial in when the old LSB was set.
    function automatic logic [CHAL_W-1:0] lfsr_next(input logic [CHAL_W-1:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_POLY : '0);
    endfunction

endpackage

// File: rtl/puf_lfsr8.sv
// 8-bit Galois LFSR that supplies the challenge vector; an all-zero seed is promoted to 0x01.
module puf_lfsr8
    import puf_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [CHAL_W-1:0] seed,
    input  logic              advance,
    output logic [CHAL_W-1:0] state
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= '0;
        end else if (load) begin
            state <= (seed == '0) ? CHAL_W'(1) : seed;
        end else if (advance) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/puf_crp_sequencer.sv
// Drives eight LFSR challenges into an arbiter PUF, majority-votes NVOTE synchronized
// evaluations per challenge and publishes the response word plus an instability mask.
module puf_crp_sequencer
    import puf_pkg::*;
#(
    parameter int NVOTE   = 5,
    parameter int SETTLE  = 4,
    parameter int PULSE_W = 4,
    parameter int CAPTURE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CHAL_W-1:0] seed,
    input  logic              response_in,
    output logic [CHAL_W-1:0] challenge,
    output logic              launch,
    output logic              busy,
    output logic              done,
    output logic [CHAL_W-1:0] resp_word,
    output logic [CHAL_W-1:0] unstable_mask
);

    localparam int PH_MAX = (SETTLE > PULSE_W)
                          ? ((SETTLE  > CAPTURE) ? SETTLE  : CAPTURE)
                          : ((PULSE_W > CAPTURE) ? PULSE_W : CAPTURE);
    localparam int CNT_W  = $clog2(PH_MAX + 1);
    localparam int IDX_W  = $clog2(CHAL_W);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic [3:0]        eval_cnt;
    logic [3:0]        ones;
    logic [CHAL_W-1:0] shadow_resp;
    logic [CHAL_W-1:0] shadow_mask;
    logic              sync1;
    logic              sync2;

    logic              bit_val;
    logic              bit_unstable;
    logic [CHAL_W-1:0] resp_next;
    logic [CHAL_W-1:0] mask_next;

    // response_in is asynchronous to clk; only sync2 may reach the vote counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= response_in;
            sync2 <= sync1;
        end
    end

    puf_lfsr8 u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (state == S_IDLE && start),
        .seed    (seed),
        .advance (state == S_NEXT),
        .state   (challenge)
    );

    assign bit_val      = (ones > 4'(NVOTE / 2));
    assign bit_unstable = (ones != 4'd0) && (ones != 4'(NVOTE));

    // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
    always_comb begin
        resp_next          = shadow_resp;
        mask_next          = shadow_mask;
        resp_next[bit_idx] = bit_val;
        mask_next[bit_idx] = bit_unstable;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            eval_cnt      <= '0;
            ones          <= '0;
            shadow_resp   <= '0;
            shadow_mask   <= '0;
            launch        <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            resp_word     <= '0;
            unstable_mask <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_SETUP;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        bit_idx  <= '0;
                        eval_cnt <= '0;
                        ones     <= '0;
                    end
                end
                S_SETUP: begin
                    if (cnt == CNT_W'(SETTLE - 1)) begin
                        cnt    <= '0;
                        launch <= 1'b1;
                        state  <= S_LAUNCH;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_LAUNCH: begin
                    if (cnt == CNT_W'(PULSE_W - 1)) begin
                        cnt    <= '0;
                        launch <= 1'b0;
                        state  <= S_HOLD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (cnt == CNT_W'(CAPTURE - 1)) begin
                        cnt   <= '0;
                        state <= S_SAMPLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_SAMPLE: begin
                    ones     <= ones + {3'b000, sync2};
                    eval_cnt <= eval_cnt + 4'd1;
                    state    <= (eval_cnt + 4'd1 < 4'(NVOTE)) ? S_SETUP : S_NEXT;
                end
                S_NEXT: begin
                    shadow_resp <= resp_next;
                    shadow_mask <= mask_next;
                    ones        <= '0;
                    eval_cnt    <= '0;
                    if (bit_idx == IDX_W'(CHAL_W - 1)) begin
                        // Publish on the edge into DONE so done and the words appear together.
                        resp_word     <= resp_next;
                        unstable_mask <= mask_next;
                        done          <= 1'b1;
                        state         <= S_DONE;
                    end else begin
                        bit_idx <= bit_idx + IDX_W'(1);
                        state   <= S_SETUP;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state  <= S_IDLE;
                    launch <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_crp_sequencer.sv
// Scoreboard bench for puf_crp_sequencer: a vote-table PUF model drives response_in per
// launch pulse and a monitor checks challenges, pulse widths and published results.
module tb_puf_crp_sequencer;

    localparam int NVOTE  = 5;
    localparam int LAT    = 529;
    localparam int PULSES = 40;

    typedef struct {
        logic [7:0] resp;
        logic [7:0] mask;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] seed = 8'h00;
    logic       response_in = 1'b0;
    logic [7:0] challenge;
    logic       launch;
    logic       busy;
    logic       done;
    logic [7:0] resp_word;
    logic [7:0] unstable_mask;

    int   n_pass = 0;
    int   n_total = 0;
    exp_t sb[$];
    bit [4:0]   votes[8];
    bit         parity_mode = 1'b0;
    logic [7:0] exp_chal[8];
    int   ecnt = 0;
    int   acc_edge = 0;
    int   rises = 0;
    int   base = 0;
    int   done_count = 0;

    puf_crp_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .seed          (seed),
        .response_in   (response_in),
        .challenge     (challenge),
        .launch        (launch),
        .busy          (busy),
        .done          (done),
        .resp_word     (resp_word),
        .unstable_mask (unstable_mask)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ecnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    endtask

    // Reference: walk the challenge sequence arithmetically and count votes per challenge.
    task automatic model_run(input logic [7:0] sd, input bit par);
        int   s;
        int   n;
        exp_t e;
        s = (sd == 8'h00) ? 1 : int'(sd);
        e.resp = 8'h00;
        e.mask = 8'h00;
        for (int i = 0; i < 8; i++) begin
            exp_chal[i] = 8'(s);
            if (par) votes[i] = {5{^(8'(s))}};
            n = $countones(votes[i]);
            e.resp[i] = (2 * n > NVOTE);
            e.mask[i] = (n != 0) && (n != NVOTE);
            s = (s / 2) ^ ((s % 2 == 1) ? 'hB8 : 0);
        end
        sb.push_back(e);
    endtask

    task automatic set_votes(input bit [4:0] v);
        for (int i = 0; i < 8; i++) votes[i] = v;
    endtask

    task automatic run(input logic [7:0] sd, input bit par, input bit extra);
        int d0;
        parity_mode = par;
        model_run(sd, par);
        d0 = done_count;
        @(negedge clk);
        seed  = sd;
        start = 1'b1;
        base  = rises;
        @(negedge clk);
        start    = 1'b0;
        seed     = 8'($urandom);
        acc_edge = ecnt;
        check("busy_after_start", busy, 1);
        for (int c = 1; c < 700 && done_count == d0; c++) begin
            @(negedge clk);
            start = extra && (c == 9 || c == 299);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("done_once", done_count - d0, 1);
        check("pulse_total", rises - base, PULSES);
        check("busy_after_done", busy, 0);
    endtask

    // Monitor: PUF model driver, pulse checks and scoreboard comparison on done.
    initial begin
        int         hi;
        int         p;
        logic       prev_launch;
        logic [7:0] chal_at_rise;
        exp_t       e;
        hi = 0;
        prev_launch = 1'b0;
        chal_at_rise = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hi = 0;
                prev_launch = 1'b0;
            end else begin
                if (launch && !prev_launch) begin
                    p = rises - base;
                    rises++;
                    if (p < PULSES) begin
                        check("challenge", challenge, exp_chal[p / NVOTE]);
                        response_in = parity_mode ? ^challenge : votes[p / NVOTE][p % NVOTE];
                    end else begin
                        check("pulse_index", p, PULSES - 1);
                    end
                    chal_at_rise = challenge;
                end
                if (launch) begin
                    hi++;
                end else if (hi > 0) begin
                    check("launch_width", hi, 4);
                    check("chal_stable", challenge, chal_at_rise);
                    hi = 0;
                end
                prev_launch = launch;
                if (done) begin
                    done_count++;
                    if (sb.size() == 0) begin
                        check("unexpected_done", done, 0);
                    end else begin
                        e = sb.pop_front();
                        check("resp_word", resp_word, e.resp);
                        check("unstable_mask", unstable_mask, e.mask);
                        check("done_cycle", ecnt - acc_edge + 1, LAT);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        repeat (3) @(negedge clk);
        check("rst_challenge", challenge, 0);
        check("rst_launch", launch, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_resp", resp_word, 0);
        check("rst_mask", unstable_mask, 0);
        rst_n = 1'b1;

        // Tied-high response, seed 0x01.
        set_votes(5'b11111);
        run(8'h01, 1'b0, 1'b0);

        // Reset in the middle of a run.
        d0 = done_count;
        parity_mode = 1'b0;
        @(negedge clk);
        seed  = 8'h5A;
        start = 1'b1;
        base  = rises;
        exp_chal[0] = 8'h5A;
        exp_chal[1] = 8'h2D;
        exp_chal[2] = 8'hAE;
        @(negedge clk);
        start = 1'b0;
        repeat (150) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_challenge", challenge, 0);
        check("arst_launch", launch, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_resp", resp_word, 0);
        check("arst_mask", unstable_mask, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("busy_after_release", busy, 0);
        repeat (20) @(negedge clk);
        check("no_partial_done", done_count - d0, 0);
        check("resp_after_release", resp_word, 0);

        // Parity PUF model.
        run(8'h01, 1'b1, 1'b0);

        // Noise on challenge 2: majority one, then majority zero.
        set_votes(5'b11111);
        votes[2] = 5'b10101;
        run(8'h01, 1'b0, 1'b0);
        set_votes(5'b11111);
        votes[2] = 5'b01010;
        run(8'h01, 1'b0, 1'b0);

        // Seed zero behaves as seed one.
        set_votes(5'b11111);
        run(8'h00, 1'b0, 1'b0);

        // Starts while busy are ignored; a fresh start afterwards runs normally.
        run(8'h01, 1'b0, 1'b1);
        run(8'($urandom), 1'b0, 1'b0);

        // Randomized seeds and vote tables.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) begin
                case ($urandom_range(2))
                    0:       votes[i] = 5'b00000;
                    1:       votes[i] = 5'b11111;
                    default: votes[i] = 5'($urandom);
                endcase
            end
            run(8'($urandom), 1'b0, 1'b0);
        end

        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/puf_crp_sequencer.md
Name: puf_crp_sequencer

Overview:
Challenge/response controller that drives the arbiter PUF stage directly downstream of it. It generates eight challenges from an 8-bit LFSR and launches a race pulse for each. It samples the PUF response through a synchronizer and majority-votes NVOTE evaluations per challenge. The result is an 8-bit response word plus a per-bit instability mask for the host logic.

Parameters:
- NVOTE, 5, evaluations per challenge; odd, 1..15.
- SETTLE, 4, cycles challenge is held stable with launch low before each pulse; >=1.
- PULSE_W, 4, cycles launch is held high; >=1.
- CAPTURE, 4, cycles after launch falls before sampling; >=2, covers the synchronizer.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; accepted only in IDLE.
- seed  in  8  LFSR seed, sampled on start acceptance.
- response_in  in  1  raw PUF arbiter output; asynchronous to clk.
- challenge  out  8  challenge vector to the PUF mux chain.
- launch  out  1  race pulse to the PUF delay-line input.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when resp_word and unstable_mask update.
- resp_word  out  8  voted response; bit i is the result for challenge i.
- unstable_mask  out  8  bit i set when the votes for challenge i were not unanimous.

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: all outputs 0, state IDLE, LFSR 0, counters 0, synchronizer flops 0.
- response_in passes through a 2-flop synchronizer; only the synchronized value is used.
- LFSR: 8-bit Galois, right shift; if the old LSB is 1, XOR with 0xB8 after the shift.
  - Seed 0x00 is replaced by 0x01.
  - challenge = LFSR state, registered.
  - The LFSR advances once per completed bit.
- States and transitions:
  - IDLE: launch=0. On start, load LFSR (seed or 0x01), clear bit index, eval count and vote count; go to SETUP next cycle.
  - SETUP: SETTLE cycles, launch=0, then LAUNCH.
  - LAUNCH: PULSE_W cycles, launch=1, then HOLD.
  - HOLD: CAPTURE cycles, launch=0, then SAMPLE.
  - SAMPLE: 1 cycle; ones += synchronized response; eval++. If eval < NVOTE, go to SETUP; else go to NEXT.
  - NEXT: 1 cycle.
    - Bit result = ones > NVOTE/2; unstable = (ones != 0) and (ones != NVOTE).
    - Write both into shadow registers at bit index.
    - Clear ones and eval; advance the LFSR.
    - If bit index = 7, go to DONE; else bit index++ and go to SETUP.
  - DONE: 1 cycle; copy shadows to resp_word/unstable_mask, done=1; then IDLE.
- Timing:
  - challenge changes only in NEXT/IDLE-accept, never while launch=1 or in HOLD.
  - E = SETTLE+PULSE_W+CAPTURE+1.
  - With start accepted at edge 0, done is high in cycle 8*(NVOTE*E+1)+1; 529 at defaults.
- Boundaries:
  - start while busy is ignored; no queuing.
  - resp_word/unstable_mask hold their last values until the next DONE.
  - Reset mid-operation returns immediately to reset values; no partial result is published.
  - Vote counter is 4 bits; no overflow for NVOTE<=15.

Decomposition:
- Shared package puf_pkg: state enum; LFSR polynomial constant 0xB8; challenge width constant 8, matching the PUF chain length.
- One sub-module: puf_lfsr8, with load, seed and advance inputs and the state output.
- Synchronizer and FSM stay inline.

Test Plan:
- Reset: assert rst_n=0 mid-run -> all outputs 0 asynchronously; busy=0 after release.
- response_in tied 1, seed 0x01, defaults:
  - challenge sequence 01,B8,5C,2E,17,B3,E1,C8;
  - launch high exactly 4 cycles per pulse, 40 pulses total;
  - resp_word=0xFF, unstable_mask=0x00, done in cycle 529.
- Bench PUF model response_in = parity(challenge), seed 0x01 -> resp_word=0xA1, unstable_mask=0x00.
- Noise on challenge 2 with response_in=1:
  - votes 1,0,1,0,1 -> bit2=1, unstable_mask=0x04;
  - votes 0,1,0,1,0 -> bit2=0, mask=0x04.
- Seed 0x00 -> identical to seed 0x01 run (first challenge 0x01, resp_word 0xFF with response_in tied 1).
- start pulsed at cycles 10 and 300 of a run -> ignored, single done at 529; new start after done runs normally.
